// File: rtl/cwc_pkg.sv
// cwc_pkg: shared defaults and FSM state type for the codeword decoder controller
package cwc_pkg;
  localparam int CW_W_DEF = 18;
  localparam int N_WORDS_DEF = 9;
  localparam int OUT_W_DEF = 8;
  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, FLUSH} state_t;
endpackage

// File: rtl/cw_dec_ctrl_if.sv
// cw_dec_ctrl_if: host codeword input and packed-bit output handshakes
interface cw_dec_ctrl_if import cwc_pkg::*; #(
  parameter int CW_W = CW_W_DEF,
  parameter int OUT_W = OUT_W_DEF
);
  localparam int NB_W = $clog2(OUT_W + 1);
  logic s_valid;
  logic s_ready;
  logic [CW_W-1:0] s_data;
  logic m_valid;
  logic m_ready;
  logic [OUT_W-1:0] m_data;
  logic [NB_W-1:0] m_nbits;
  logic m_last;
  modport slave (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data, m_nbits, m_last);
  modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data, m_nbits, m_last);
endinterface

// File: rtl/cw_out_fifo.sv
// cw_out_fifo: synchronous show-ahead FIFO, push accepted when full if a pop happens the same cycle
module cw_out_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_b,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic empty,
  output logic full
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rd];
  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      rd <= '0;
      wr <= '0;
      cnt <= '0;
    end else begin
      rd <= do_pop ? (rd == AW'(DEPTH - 1) ? '0 : rd + AW'(1)) : rd;
      wr <= do_push ? (wr == AW'(DEPTH - 1) ? '0 : wr + AW'(1)) : wr;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  // storage array, contents are don't-care while empty
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
endmodule

// File: rtl/cw_dec_ctrl.sv
// cw_dec_ctrl: loads a codeword frame into the decoder and packs its serial output bits into words
module cw_dec_ctrl import cwc_pkg::*; #(
  parameter int CW_W = CW_W_DEF,
  parameter int N_WORDS = N_WORDS_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst_b,
  cw_dec_ctrl_if.slave bus,
  output logic [CW_W-1:0] dec_msg_bype,
  output logic dec_wr_en,
  output logic dec_start,
  input  logic dec_bin_msg,
  input  logic dec_msg_rdy,
  input  logic dec_msg_done,
  output logic busy,
  output logic err_ovf,
  output logic err_tmo,
  input  logic clr_err
);
  localparam int NB_W = $clog2(OUT_W + 1);
  localparam int WC_W = $clog2(N_WORDS + 1);
  localparam int TM_W = $clog2(TIMEOUT + 1);
  localparam int E_W = OUT_W + NB_W + 1;
  state_t state, state_n;
  logic [WC_W-1:0] wcnt;
  logic [TM_W-1:0] timer;
  logic [OUT_W-1:0] pk, pk_n, word;
  logic [NB_W-1:0] cnt, cnt_n;
  logic acc, bit_in, done_ev, tmo_ev, fin, full, push, can_push, new_drop, side_v;
  logic f_push, f_pop, f_empty, f_full;
  logic [E_W-1:0] ent, side, f_din, f_dout;
  assign acc = bus.s_valid && bus.s_ready;
  assign bit_in = state == RUN && dec_msg_rdy;
  assign done_ev = state == RUN && dec_msg_done;
  assign tmo_ev = state == RUN && !dec_msg_done && timer == TM_W'(TIMEOUT);
  assign fin = done_ev || tmo_ev;
  assign pk_n = bit_in ? {pk[OUT_W-2:0], dec_bin_msg} : pk;
  assign cnt_n = cnt + NB_W'(bit_in);
  assign full = cnt_n == NB_W'(OUT_W);
  assign push = full || fin;
  assign word = pk_n << (NB_W'(OUT_W) - cnt_n);
  assign ent = {word, cnt_n, fin};
  assign f_pop = bus.m_valid && bus.m_ready;
  assign can_push = !f_full || f_pop;
  assign f_push = (side_v || push) && can_push;
  assign f_din = side_v ? side : ent;
  assign new_drop = push && (side_v || !can_push);
  assign busy = state != IDLE;
  assign bus.m_valid = !f_empty;
  assign {bus.m_data, bus.m_nbits, bus.m_last} = f_dout;
  // state register
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) state <= IDLE;
    else state <= state_n;
  // next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = acc ? (N_WORDS == 1 ? START : LOAD) : IDLE;
      LOAD:  state_n = acc && wcnt == WC_W'(N_WORDS - 1) ? START : LOAD;
      START: state_n = RUN;
      RUN:   state_n = fin ? FLUSH : RUN;
      FLUSH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // host intake, decoder load strobes and run timer; s_ready tracks the upcoming state
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      wcnt <= '0;
      timer <= '0;
      dec_wr_en <= 1'b0;
      dec_start <= 1'b0;
      dec_msg_bype <= '0;
      bus.s_ready <= 1'b0;
    end else begin
      wcnt <= acc ? (state == IDLE ? WC_W'(1) : wcnt + WC_W'(1)) : wcnt;
      timer <= state == RUN ? timer + TM_W'(1) : '0;
      dec_wr_en <= acc;
      dec_start <= state == START;
      dec_msg_bype <= acc ? bus.s_data : dec_msg_bype;
      bus.s_ready <= state_n == IDLE || state_n == LOAD;
    end
  // bit packer, cleared whenever a word leaves or outside RUN
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      pk <= '0;
      cnt <= '0;
    end else begin
      pk <= push || state != RUN ? '0 : pk_n;
      cnt <= push || state != RUN ? '0 : cnt_n;
    end
  // terminator side slot and sticky error flags; a new event beats clr_err
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      side_v <= 1'b0;
      side <= '0;
      err_ovf <= 1'b0;
      err_tmo <= 1'b0;
    end else begin
      side_v <= new_drop && ent[0] ? 1'b1 : side_v && !can_push;
      side <= new_drop && ent[0] ? ent : side;
      err_ovf <= new_drop || (err_ovf && !clr_err);
      err_tmo <= tmo_ev || (err_tmo && !clr_err);
    end
  cw_out_fifo #(.W(E_W), .DEPTH(4)) u_fifo (
    .clk(clk),
    .rst_b(rst_b),
    .push(f_push),
    .pop(f_pop),
    .din(f_din),
    .dout(f_dout),
    .empty(f_empty),
    .full(f_full)
  );
endmodule

// File: tb/tb_cw_dec_ctrl.sv
// tb_cw_dec_ctrl: directed checks of frame loading, bit packing, overflow, timeout and reset
`timescale 1ns/1ps
module tb_cw_dec_ctrl;
  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic [17:0] dec_msg_bype;
  logic dec_wr_en, dec_start, busy, err_ovf, err_tmo;
  logic dec_bin_msg, dec_msg_rdy, dec_msg_done, clr_err;
  int vectors = 0;
  int miscompares = 0;
  logic [17:0] words [9];
  logic bits [$];
  logic [12:0] got [$];
  always #5 clk = ~clk;
  cw_dec_ctrl_if #(.CW_W(18), .OUT_W(8)) bus ();
  cw_dec_ctrl #(.CW_W(18), .N_WORDS(9), .OUT_W(8), .TIMEOUT(64)) dut (
    .clk(clk),
    .rst_b(rst_b),
    .bus(bus),
    .dec_msg_bype(dec_msg_bype),
    .dec_wr_en(dec_wr_en),
    .dec_start(dec_start),
    .dec_bin_msg(dec_bin_msg),
    .dec_msg_rdy(dec_msg_rdy),
    .dec_msg_done(dec_msg_done),
    .busy(busy),
    .err_ovf(err_ovf),
    .err_tmo(err_tmo),
    .clr_err(clr_err)
  );
  always @(negedge clk)
    if (rst_b && bus.m_valid && bus.m_ready) got.push_back({bus.m_data, bus.m_nbits, bus.m_last});
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic add_bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bits.push_back(v[i]);
  endtask
  task automatic load_frame();
    int k = 0;
    while (!bus.s_ready && k < 50) begin
      step();
      k++;
    end
    chk("s_ready_idle", bus.s_ready, 1);
    bus.s_valid = 1'b1;
    bus.s_data = words[0];
    for (int i = 0; i < 9; i++) begin
      step();
      if (i < 8) bus.s_data = words[i+1];
      else bus.s_valid = 1'b0;
      chk("wr_en", dec_wr_en, 1);
      chk("bype", dec_msg_bype, words[i]);
      chk("start_early", dec_start, 0);
    end
    chk("s_ready_drop", bus.s_ready, 0);
    step();
    chk("wr_en_end", dec_wr_en, 0);
    chk("start", dec_start, 1);
    chk("busy_run", busy, 1);
  endtask
  task automatic send_bits(input logic done_last);
    int n = bits.size();
    for (int i = 0; i < n; i++) begin
      dec_msg_rdy = 1'b1;
      dec_bin_msg = bits[i];
      dec_msg_done = done_last && i == n - 1;
      step();
      if (i == 0) chk("start_pulse", dec_start, 0);
    end
    dec_msg_rdy = 1'b0;
    dec_msg_done = 1'b0;
    dec_bin_msg = 1'b0;
    bits.delete();
  endtask
  task automatic done_pulse();
    dec_msg_done = 1'b1;
    step();
    dec_msg_done = 1'b0;
  endtask
  task automatic expect_entry(input string tag, input logic [7:0] d, input logic [3:0] nb, input logic l);
    int k = 0;
    logic [12:0] e;
    while (got.size() == 0 && k < 200) begin
      step();
      k++;
    end
    chk({tag, "_present"}, 32'(got.size() != 0), 1);
    if (got.size() != 0) begin
      e = got.pop_front();
      chk(tag, e, {d, nb, l});
    end
  endtask
  initial begin
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.m_ready = 1'b1;
    dec_bin_msg = 1'b0;
    dec_msg_rdy = 1'b0;
    dec_msg_done = 1'b0;
    clr_err = 1'b0;
    #12;
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_wr_en", dec_wr_en, 0);
    chk("rst_start", dec_start, 0);
    chk("rst_bype", dec_msg_bype, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_m_nbits", bus.m_nbits, 0);
    chk("rst_m_last", bus.m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_ovf", err_ovf, 0);
    chk("rst_err_tmo", err_tmo, 0);
    step();
    rst_b = 1'b1;
    step();
    chk("s_ready_release", bus.s_ready, 1);
    words = '{18'd8234, 18'd26338, 18'd15220, 18'd17452, 18'd48933, 18'd84905, 18'd28089, 18'd24079, 18'd3758};
    load_frame();
    add_bits(8'hA5, 8);
    add_bits(8'h3C, 8);
    add_bits(8'h09, 4);
    send_bits(1'b0);
    done_pulse();
    chk("busy_flush", busy, 1);
    step();
    chk("busy_idle", busy, 0);
    expect_entry("f1_w0", 8'hA5, 4'd8, 1'b0);
    expect_entry("f1_w1", 8'h3C, 4'd8, 1'b0);
    expect_entry("f1_w2", 8'h90, 4'd4, 1'b1);
    chk("f1_err_ovf", err_ovf, 0);
    chk("f1_err_tmo", err_tmo, 0);
    load_frame();
    add_bits(8'h12, 8);
    add_bits(8'h34, 8);
    send_bits(1'b1);
    expect_entry("f2_w0", 8'h12, 4'd8, 1'b0);
    expect_entry("f2_w1", 8'h34, 4'd8, 1'b1);
    step(5);
    chk("f2_no_extra", got.size(), 0);
    load_frame();
    add_bits(8'hDE, 8);
    add_bits(8'hAD, 8);
    send_bits(1'b0);
    done_pulse();
    expect_entry("f3_w0", 8'hDE, 4'd8, 1'b0);
    expect_entry("f3_w1", 8'hAD, 4'd8, 1'b0);
    expect_entry("f3_term", 8'h00, 4'd0, 1'b1);
    bus.m_ready = 1'b0;
    load_frame();
    for (int i = 1; i <= 6; i++) add_bits(8'(i * 17), 8);
    send_bits(1'b1);
    step();
    chk("ovf_flag", err_ovf, 1);
    chk("ovf_m_valid", bus.m_valid, 1);
    chk("ovf_head", bus.m_data, 8'h11);
    step(3);
    bus.m_ready = 1'b1;
    expect_entry("ovf_w0", 8'h11, 4'd8, 1'b0);
    expect_entry("ovf_w1", 8'h22, 4'd8, 1'b0);
    expect_entry("ovf_w2", 8'h33, 4'd8, 1'b0);
    expect_entry("ovf_w3", 8'h44, 4'd8, 1'b0);
    expect_entry("ovf_term", 8'h66, 4'd8, 1'b1);
    step(5);
    chk("ovf_no_extra", got.size(), 0);
    chk("ovf_sticky", err_ovf, 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("ovf_clear", err_ovf, 0);
    load_frame();
    add_bits(8'h05, 3);
    send_bits(1'b0);
    step(61);
    chk("tmo_before", err_tmo, 0);
    chk("tmo_busy_run", busy, 1);
    clr_err = 1'b1;
    step();
    chk("tmo_set_beats_clr", err_tmo, 1);
    chk("tmo_busy_flush", busy, 1);
    step();
    clr_err = 1'b0;
    chk("tmo_busy_idle", busy, 0);
    chk("tmo_cleared", err_tmo, 0);
    expect_entry("tmo_term", 8'hA0, 4'd3, 1'b1);
    words = '{18'h3FFFF, 18'h00001, 18'h2AAAA, 18'h15555, 18'h00100, 18'h12345, 18'h3C3C3, 18'h0F0F0, 18'h20000};
    bus.s_valid = 1'b1;
    bus.s_data = 18'h11111;
    for (int i = 0; i < 5; i++) step();
    rst_b = 1'b0;
    bus.s_valid = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_s_ready", bus.s_ready, 0);
    chk("mid_rst_wr_en", dec_wr_en, 0);
    chk("mid_rst_bype", dec_msg_bype, 0);
    step();
    rst_b = 1'b1;
    step();
    chk("mid_rst_release", bus.s_ready, 1);
    load_frame();
    add_bits(8'hC3, 8);
    send_bits(1'b1);
    expect_entry("rst_frame", 8'hC3, 4'd8, 1'b1);
    step(5);
    chk("rst_no_extra", got.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cw_dec_ctrl.md
CW_DEC_CTRL -- requirements
Module: cw_dec_ctrl

Interface
REQ-001 Parameter CW_W, default 18, codeword word width fed to the decoder.
REQ-002 Parameter N_WORDS, default 9, codeword words per frame.
REQ-003 Parameter OUT_W, default 8, packed output word width.
REQ-004 Parameter TIMEOUT, default 4096, max cycles from dec_start to dec_msg_done.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst_b  in  1  asynchronous active-low reset.
REQ-007 s_valid / s_ready  in / out  1 / 1  host codeword handshake.
REQ-008 s_data  in  CW_W  host codeword word.
REQ-009 dec_msg_bype / dec_wr_en / dec_start  out  CW_W / 1 / 1  decoder load bus, write strobe, start pulse.
REQ-010 dec_bin_msg / dec_msg_rdy / dec_msg_done  in  1 / 1 / 1  decoder serial bit, bit-valid, frame-end.
REQ-011 m_valid / m_ready  out / in  1 / 1  packed output handshake.
REQ-012 m_data / m_nbits / m_last  out  OUT_W / clog2(OUT_W+1) / 1  packed bits, valid-bit count, frame end.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 err_ovf / err_tmo  out  1 / 1  sticky overflow / timeout flags; clr_err  in  1  clears both.

Function
REQ-015 FSM states IDLE, LOAD, START, RUN, FLUSH; all decoder-side outputs registered.
REQ-016 s_ready SHALL be 1 only in IDLE and LOAD; an accepted word (s_valid&&s_ready) in IDLE moves to LOAD with word count 1.
REQ-017 Word accepted at cycle t SHALL appear as dec_wr_en=1 with dec_msg_bype=s_data at t+1; dec_wr_en is 0 otherwise.
REQ-018 On the N_WORDS-th accept, s_ready SHALL drop next cycle; FSM enters START, dec_start=1 exactly one cycle, two cycles after that accept (one cycle after the last dec_wr_en).
REQ-019 START -> RUN unconditionally; RUN timer loads 0 and increments each cycle.
REQ-020 In RUN, each cycle with dec_msg_rdy=1 SHALL shift dec_bin_msg into the pack register MSB-first (first bit lands in m_data[OUT_W-1]) and increment bit count.
REQ-021 When bit count reaches OUT_W, pack register SHALL be pushed to the output FIFO with nbits=OUT_W, last=0, count reset to 0.
REQ-022 dec_msg_done in RUN: a bit with dec_msg_rdy on the same cycle is counted first; then exactly one entry with last=1 is pushed: the completing word if count reached OUT_W, else zero-padded partial word with nbits=count (0..OUT_W-1; nbits=0 means empty terminator); FSM -> FLUSH.
REQ-023 FLUSH -> IDLE next cycle; next frame may load while FIFO drains.
REQ-024 Timer reaching TIMEOUT in RUN without dec_msg_done SHALL set err_tmo, push terminator as in REQ-022, go FLUSH.
REQ-025 dec_msg_rdy/dec_msg_done outside RUN SHALL be ignored.
REQ-026 Output FIFO depth 4; m_valid = not empty; pop on m_valid&&m_ready; push and pop same cycle when full SHALL both succeed.
REQ-027 Push while full without pop SHALL drop the entry and set err_ovf; a dropped terminator is retained in a 1-entry side slot and delivered when space exists.
REQ-028 clr_err SHALL clear flags next cycle; a simultaneous new error event wins (flag stays 1).

Reset
REQ-029 rst_b low SHALL asynchronously force IDLE, counters/timer/pack register 0, FIFO empty, and outputs s_ready=0 during reset, dec_wr_en=0, dec_start=0, dec_msg_bype=0, m_valid=0, m_data=0, m_nbits=0, m_last=0, busy=0, err_ovf=0, err_tmo=0.
REQ-030 Reset mid-frame SHALL discard partial frame; s_ready=1 first cycle after rst_b release.

Structure
REQ-031 Shared package cwc_pkg holds CW_W, N_WORDS, OUT_W defaults and the FSM state enum.
REQ-032 Output FIFO SHALL be sub-module cw_out_fifo (sync, parameterised width/depth).

Verification
REQ-033 Load 8234,26338,15220,17452,48933,84905,28089,24079,3758 with s_valid held -> 9 consecutive dec_wr_en cycles, same values/order, one dec_start cycle immediately after.
REQ-034 Stub emits 20 bits 0xA5,0x3C,0x9 (MSB-first) then done -> entries A5/8/0, 3C/8/0, 90/4/1.
REQ-035 16 bits with done on 16th bit -> two entries, second nbits=8 last=1; with done a cycle later -> third entry nbits=0 last=1.
REQ-036 m_ready=0 during 48-bit frame -> 4 entries kept, err_ovf=1, terminator delivered after drain; clr_err -> 0.
REQ-037 No done, TIMEOUT=64 -> err_tmo=1 at cycle 64 of RUN, terminator pushed, busy=0 two cycles later.
REQ-038 rst_b low after 5 words loaded -> immediate IDLE; following full 9-word frame decodes correctly.
